// File: rtl/input_buffer_pkg.sv
// Shared defaults and helpers for the router input buffer.
// The optional parity checker is enabled with INPUT_BUFFER_PARITY_CHECK_EN.
package input_buffer_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int BUFFER_DEPTH   = 4;
    localparam int BUFFER_PTR_W   = 2;

    // Upstream registers its flit one cycle after sampling ready, so two free
    // slots are needed: one for the flit already in flight, one for the next.
    function automatic logic has_headroom(input int depth, input int occupancy);
        return (depth - occupancy) >= 2;
    endfunction

endpackage

// File: rtl/parity_checker.sv
// Combinational even-parity checker over a whole flit (parity bit is the MSB).
// Reused by the network interface as well as the router input buffer.
module parity_checker #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] data,
    output logic             error
);

    assign error = ^data;

endmodule

// File: rtl/input_buffer.sv
// Router-to-router link receive FIFO with first-word-fall-through head flit.
// Define INPUT_BUFFER_PARITY_CHECK_EN to build the per-write parity checker.
module input_buffer
    import input_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = BUFFER_DEPTH,
    parameter int PTR_W      = BUFFER_PTR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  ready_out,
    input  logic                  read_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic [PTR_W:0]        count,
    output logic                  overflow,
    output logic                  parity_err
);

    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] ONE_COUNT  = (PTR_W+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic [PTR_W:0]   count_next;
    logic             ready_reg;
    logic             overflow_reg;
    logic             wr_accept;
    logic             rd_accept;
    logic             wr_drop;

    // A write into a full FIFO is still accepted when the head leaves the same cycle.
    always_comb begin
        rd_accept  = read_en && (count_reg != '0);
        wr_accept  = valid_in && ((count_reg != FULL_COUNT) || rd_accept);
        wr_drop    = valid_in && !wr_accept;
        count_next = count_reg;
        if (wr_accept && !rd_accept) begin
            count_next = count_reg + ONE_COUNT;
        end else if (!wr_accept && rd_accept) begin
            count_next = count_reg - ONE_COUNT;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            ready_reg    <= 1'b1;
            overflow_reg <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (rd_accept) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            ready_reg <= has_headroom(DEPTH, int'(count_next));
            if (wr_drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    assign data_out  = mem[rd_ptr_reg];
    assign empty     = (count_reg == '0);
    assign count     = count_reg;
    assign ready_out = ready_reg;
    assign overflow  = overflow_reg;

`ifdef INPUT_BUFFER_PARITY_CHECK_EN
    logic parity_bad;
    logic parity_err_reg;

    parity_checker #(
        .WIDTH (DATA_WIDTH)
    ) u_parity_checker (
        .data  (data_in),
        .error (parity_bad)
    );

    // Flagged flits are still stored; the error is a one-cycle notification only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_err_reg <= 1'b0;
        end else begin
            parity_err_reg <= wr_accept && parity_bad;
        end
    end

    assign parity_err = parity_err_reg;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_input_buffer.sv
// Directed self-checking bench for input_buffer.
// Parity scenario depends on INPUT_BUFFER_PARITY_CHECK_EN.
module tb_input_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic        ready_out;
    logic        read_en = 1'b0;
    logic [31:0] data_out;
    logic        empty;
    logic [2:0]  count;
    logic        overflow;
    logic        parity_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    input_buffer #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .PTR_W      (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .ready_out  (ready_out),
        .read_en    (read_en),
        .data_out   (data_out),
        .empty      (empty),
        .count      (count),
        .overflow   (overflow),
        .parity_err (parity_err)
    );

    task automatic test_reset();
        rst = 1'b0; valid_in = 1'b1; data_in = 32'h55; read_en = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_out); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL reset_parity got=%b want=0", parity_err); end
        valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL release_count got=%0d want=0", count); end
        $display("reset: released count=%0d ready=%b", count, ready_out);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; data_in = 32'(i + 1);
            @(negedge clk);
            $display("fill: wrote %h count=%0d ready=%b", data_in, count, ready_out);
            total++; if (count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count i=%0d got=%0d want=%0d", i, count, i + 1); end
            total++; if (data_out !== 32'h1) begin bad++; $display("FAIL fill_head i=%0d got=%h want=00000001", i, data_out); end
            total++; if (ready_out !== (i < 2)) begin bad++; $display("FAIL fill_ready i=%0d got=%b want=%b", i, ready_out, (i < 2)); end
        end
        valid_in = 1'b0;
    endtask

    task automatic test_drain();
        read_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++; if (data_out !== 32'(i + 1)) begin bad++; $display("FAIL drain_data i=%0d got=%h want=%h", i, data_out, 32'(i + 1)); end
            @(negedge clk);
            $display("drain: popped %h count=%0d", 32'(i + 1), count);
            total++; if (count !== 3'(3 - i)) begin bad++; $display("FAIL drain_count i=%0d got=%0d want=%0d", i, count, 3 - i); end
        end
        @(negedge clk);
        read_en = 1'b0;
        $display("drain: extra read on empty count=%0d", count);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL drain_extra_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got=%b want=1", empty); end
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL drain_ready got=%b want=1", ready_out); end
    endtask

    task automatic test_stream();
        logic [31:0] head;
        valid_in = 1'b1; data_in = 32'h50;
        @(negedge clk);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_prime_count got=%0d want=1", count); end
        head = 32'h50;
        for (int i = 0; i < 10; i++) begin
            total++; if (data_out !== head) begin bad++; $display("FAIL stream_head i=%0d got=%h want=%h", i, data_out, head); end
            valid_in = 1'b1; read_en = 1'b1; data_in = 32'hA0 + 32'(i);
            @(negedge clk);
            $display("stream: in=%h out=%h count=%0d", data_in, head, count);
            head = 32'hA0 + 32'(i);
            total++; if (count !== 3'd1) begin bad++; $display("FAIL stream_count i=%0d got=%0d want=1", i, count); end
            total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%b want=1", i, ready_out); end
            total++; if (overflow !== 1'b0) begin bad++; $display("FAIL stream_overflow i=%0d got=%b want=0", i, overflow); end
        end
        valid_in = 1'b0;
        total++; if (data_out !== 32'hA9) begin bad++; $display("FAIL stream_last got=%h want=000000a9", data_out); end
        @(negedge clk);
        read_en = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL stream_empty got=%b want=1", empty); end
    endtask

    task automatic test_empty_rw();
        valid_in = 1'b1; read_en = 1'b1; data_in = 32'hC0;
        @(negedge clk);
        valid_in = 1'b0; read_en = 1'b0;
        $display("empty_rw: wrote %h with read count=%0d", 32'hC0, count);
        total++; if (count !== 3'd1) begin bad++; $display("FAIL empty_rw_count got=%0d want=1", count); end
        total++; if (data_out !== 32'hC0) begin bad++; $display("FAIL empty_rw_head got=%h want=000000c0", data_out); end
        read_en = 1'b1;
        @(negedge clk);
        read_en = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_rw_drain got=%b want=1", empty); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; data_in = 32'hB0 + 32'(i);
            @(negedge clk);
            $display("overflow: wrote %h count=%0d", data_in, count);
        end
        total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_full_count got=%0d want=4", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b want=0", overflow); end
        total++; if (ready_out !== 1'b0) begin bad++; $display("FAIL ovf_ready got=%b want=0", ready_out); end
        valid_in = 1'b1; read_en = 1'b1; data_in = 32'hB4;
        @(negedge clk);
        $display("overflow: write %h with read while full count=%0d", data_in, count);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_rw_count got=%0d want=4", count); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_rw_flag got=%b want=0", overflow); end
        read_en = 1'b0; data_in = 32'hDEAD;
        @(negedge clk);
        valid_in = 1'b0;
        $display("overflow: dropped %h count=%0d overflow=%b", 32'hDEAD, count, overflow);
        total++; if (count !== 3'd4) begin bad++; $display("FAIL ovf_drop_count got=%0d want=4", count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b want=1", overflow); end
        @(negedge clk);
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b want=1", overflow); end
        read_en = 1'b1;
        for (int i = 1; i < 5; i++) begin
            total++; if (data_out !== 32'hB0 + 32'(i)) begin bad++; $display("FAIL ovf_drain i=%0d got=%h want=%h", i, data_out, 32'hB0 + 32'(i)); end
            @(negedge clk);
        end
        read_en = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL ovf_empty got=%b want=1", empty); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_after_drain got=%b want=1", overflow); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1; data_in = 32'hE0 + 32'(i);
            @(negedge clk);
        end
        total++; if (count !== 3'd2) begin bad++; $display("FAIL mid_pre_count got=%0d want=2", count); end
        data_in = 32'hE2;
        #2 rst = 1'b0;
        #1;
        $display("reset_mid: asserted count=%0d overflow=%b", count, overflow);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_count got=%0d want=0", count); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL mid_empty got=%b want=1", empty); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL mid_overflow got=%b want=0", overflow); end
        total++; if (ready_out !== 1'b1) begin bad++; $display("FAIL mid_ready got=%b want=1", ready_out); end
        @(negedge clk);
        valid_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++; if (count !== 3'd0) begin bad++; $display("FAIL mid_release_count got=%0d want=0", count); end
    endtask

    task automatic test_parity();
`ifdef INPUT_BUFFER_PARITY_CHECK_EN
        valid_in = 1'b1; data_in = 32'h3;
        @(negedge clk);
        $display("parity: wrote %h parity_err=%b", data_in, parity_err);
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL parity_good got=%b want=0", parity_err); end
        data_in = 32'h1;
        @(negedge clk);
        valid_in = 1'b0;
        $display("parity: wrote %h parity_err=%b", data_in, parity_err);
        total++; if (parity_err !== 1'b1) begin bad++; $display("FAIL parity_bad got=%b want=1", parity_err); end
        @(negedge clk);
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL parity_pulse got=%b want=0", parity_err); end
`else
        valid_in = 1'b1; data_in = 32'h3;
        @(negedge clk);
        data_in = 32'h1;
        @(negedge clk);
        valid_in = 1'b0;
        $display("parity: checker absent parity_err=%b", parity_err);
        total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL parity_tied got=%b want=0", parity_err); end
`endif
        total++; if (count !== 3'd2) begin bad++; $display("FAIL parity_count got=%0d want=2", count); end
        read_en = 1'b1;
        total++; if (data_out !== 32'h3) begin bad++; $display("FAIL parity_read0 got=%h want=00000003", data_out); end
        @(negedge clk);
        total++; if (data_out !== 32'h1) begin bad++; $display("FAIL parity_read1 got=%h want=00000001", data_out); end
        @(negedge clk);
        read_en = 1'b0;
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL parity_empty got=%b want=1", empty); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_stream();
        test_empty_rw();
        test_overflow();
        test_reset_mid();
        test_parity();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
